// File: rtl/mem_wb_load_if.sv
// mem_wb_load_if: memory-stage inputs, SRAM read data and write-back outputs for mem_wb_load.
interface mem_wb_load_if;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic [7:0]  mem_aluop;
  logic [1:0]  mem_addr_lo;
  logic        mem_cp0_reg_we;
  logic [4:0]  mem_cp0_reg_write_addr;
  logic [31:0] mem_cp0_reg_data;
  logic [31:0] mem_pc;
  logic [31:0] data_sram_rdata;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        wb_whilo;
  logic        wb_cp0_reg_we;
  logic [4:0]  wb_cp0_reg_write_addr;
  logic [31:0] wb_cp0_reg_data;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  modport master (
    output stall, flush, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop,
           mem_addr_lo, mem_cp0_reg_we, mem_cp0_reg_write_addr, mem_cp0_reg_data, mem_pc,
           data_sram_rdata,
    input  wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo, wb_cp0_reg_we,
           wb_cp0_reg_write_addr, wb_cp0_reg_data, debug_wb_pc, debug_wb_rf_wen,
           debug_wb_rf_wnum, debug_wb_rf_wdata
  );
  modport slave (
    input  stall, flush, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop,
           mem_addr_lo, mem_cp0_reg_we, mem_cp0_reg_write_addr, mem_cp0_reg_data, mem_pc,
           data_sram_rdata,
    output wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo, wb_cp0_reg_we,
           wb_cp0_reg_write_addr, wb_cp0_reg_data, debug_wb_pc, debug_wb_rf_wen,
           debug_wb_rf_wnum, debug_wb_rf_wdata
  );
endinterface

// File: rtl/mem_wb_load.sv
// mem_wb_load: MEM/WB pipeline register with load-data extraction and read-data hold across stalls.
module mem_wb_load (
  input logic clk,
  input logic rst,
  mem_wb_load_if.slave b
);
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [7:0]  aluop;
    logic [1:0]  off;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_data;
    logic [31:0] pc;
  } wb_reg_t;
  wb_reg_t     r;
  logic        first;
  logic [31:0] rhold, raw, wdata;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        unused_stall;
  assign unused_stall = ^b.stall[3:0];
  // An all-zero record is a bubble: EXE_NOP_OP is 0 and every enable is cleared.
  always_ff @(posedge clk) begin
    if (rst || b.flush || (b.stall[4] && !b.stall[5])) begin
      r     <= '0;
      first <= 1'b0;
    end else if (!b.stall[4]) begin
      r     <= '{b.mem_wd, b.mem_wreg, b.mem_wdata, b.mem_hi, b.mem_lo, b.mem_whilo, b.mem_aluop,
                 b.mem_addr_lo, b.mem_cp0_reg_we, b.mem_cp0_reg_write_addr, b.mem_cp0_reg_data,
                 b.mem_pc};
      first <= 1'b1;
    end else
      first <= 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) rhold <= '0;
    else if (first) rhold <= b.data_sram_rdata;
  end
  always_comb begin
    raw    = first ? b.data_sram_rdata : rhold;
    byte_v = raw[{r.off, 3'b000} +: 8];
    half_v = r.off == 2'b00 ? raw[15:0] : r.off == 2'b10 ? raw[31:16] : 16'h0;
    wdata  = r.aluop == EXE_LB_OP  ? {{24{byte_v[7]}}, byte_v} :
             r.aluop == EXE_LBU_OP ? {24'h0, byte_v} :
             r.aluop == EXE_LH_OP  ? {{16{half_v[15]}}, half_v} :
             r.aluop == EXE_LHU_OP ? {16'h0, half_v} :
             r.aluop == EXE_LW_OP  ? raw : r.wdata;
  end
  assign b.wb_wd                 = r.wd;
  assign b.wb_wreg               = r.wreg;
  assign b.wb_wdata              = wdata;
  assign b.wb_hi                 = r.hi;
  assign b.wb_lo                 = r.lo;
  assign b.wb_whilo              = r.whilo;
  assign b.wb_cp0_reg_we         = r.cp0_we;
  assign b.wb_cp0_reg_write_addr = r.cp0_addr;
  assign b.wb_cp0_reg_data       = r.cp0_data;
  assign b.debug_wb_pc           = r.pc;
  assign b.debug_wb_rf_wen       = {4{r.wreg & first}};
  assign b.debug_wb_rf_wnum      = r.wd;
  assign b.debug_wb_rf_wdata     = wdata;
endmodule
